// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours: instruction-memory port,
// hazard/branch controls coming in, and the IF/ID register going out to decode.
interface fetch_stage_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       if_id_instr;
    logic [ADDR_W-1:0] if_id_pc4;
    logic              if_id_valid;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_data,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_data,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, instruction-memory addressing and
// the IF/ID pipeline slot with stall (hold) and redirect (flush), plus a debug fetch counter.
module fetch_stage #(
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       if_id_instr;
    logic [ADDR_W-1:0] if_id_pc4;
    logic              if_id_valid;
    logic [CNT_W-1:0]  fetch_count;

    // Wraps modulo 2^ADDR_W, so the last word of memory is followed by address 0.
    assign pc_plus4 = pc + ADDR_W'(4);

    // Priority: reset, then redirect (flush + jump), then stall (hold), then normal fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_ADDR;
            if_id_instr <= 32'h0000_0000;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else if (bus.redirect) begin
            pc          <= bus.redirect_pc & WORD_MASK;
            if_id_instr <= 32'h0000_0000;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (!bus.stall) begin
            pc          <= pc_plus4;
            if_id_instr <= bus.imem_data;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            if (fetch_count != '1) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_id_instr = if_id_instr;
    assign bus.if_id_pc4   = if_id_pc4;
    assign bus.if_id_valid = if_id_valid;
    assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model pushes the expected
// post-edge state into a queue as each cycle's stimulus is driven; it is popped and compared after the edge.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pc4;
        logic        valid;
        logic [15:0] cnt;
        logic [9:0]  pc;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] imem [0:255];

    logic [9:0]  mPc;
    logic [31:0] mInstr;
    logic [9:0]  mPc4;
    logic        mValid;
    logic [15:0] mCnt;

    fetch_stage_if #(.ADDR_W(10), .CNT_W(16)) bus ();

    fetch_stage #(.ADDR_W(10), .RESET_PC(0), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = imem[bus.imem_addr[9:2]];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, predict the state after the edge, then compare against the popped prediction.
    task automatic applyStimulus(input logic rn, input logic st, input logic rd, input logic [9:0] rpc);
        exp_t e;
        rst_n           = rn;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        if (!rn) begin
            mPc = 10'd0; mInstr = 32'h0; mPc4 = 10'd0; mValid = 1'b0; mCnt = 16'd0;
        end else if (rd) begin
            mPc = {rpc[9:2], 2'b00}; mInstr = 32'h0; mPc4 = 10'd0; mValid = 1'b0;
        end else if (!st) begin
            mInstr = imem[mPc / 4];
            mPc    = mPc + 10'd4;
            mPc4   = mPc;
            mValid = 1'b1;
            if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        end
        e.instr = mInstr; e.pc4 = mPc4; e.valid = mValid; e.cnt = mCnt; e.pc = mPc;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput("instr", bus.if_id_instr, e.instr);
        checkOutput("pc4",   32'(bus.if_id_pc4), 32'(e.pc4));
        checkOutput("valid", 32'(bus.if_id_valid), 32'(e.valid));
        checkOutput("count", 32'(bus.fetch_count), 32'(e.cnt));
        checkOutput("pc",    32'(bus.imem_addr), 32'(e.pc));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'hA500_0000 | 32'(i * 7);
        imem[0]   = 32'h2021_0001;
        imem[1]   = 32'h03FF_F820;
        imem[3]   = 32'h1022_FFFC;
        imem[8]   = 32'h0064_2820;
        imem[255] = 32'hDEAD_0FFC;

        // Reset, then the first two fetches.
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0);
        checkOutput("rst_valid", 32'(bus.if_id_valid), 32'd0);
        checkOutput("rst_pc", 32'(bus.imem_addr), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        checkOutput("first_instr", bus.if_id_instr, 32'h2021_0001);
        checkOutput("first_pc4", 32'(bus.if_id_pc4), 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        checkOutput("second_instr", bus.if_id_instr, 32'h03FF_F820);
        checkOutput("second_pc4", 32'(bus.if_id_pc4), 32'd8);
        checkOutput("count_2", 32'(bus.fetch_count), 32'd2);

        // Stall three cycles while IF/ID holds the word from 12.
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
            checkOutput("stall_instr", bus.if_id_instr, 32'h1022_FFFC);
            checkOutput("stall_pc4", 32'(bus.if_id_pc4), 32'd16);
            checkOutput("stall_pc", 32'(bus.imem_addr), 32'd16);
            checkOutput("stall_count", 32'(bus.fetch_count), 32'd4);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        checkOutput("after_stall_instr", bus.if_id_instr, imem[4]);

        // Redirect to 32 while pc=20.
        checkOutput("pre_redirect_pc", 32'(bus.imem_addr), 32'd20);
        applyStimulus(1'b1, 1'b0, 1'b1, 10'd32);
        checkOutput("redir_pc", 32'(bus.imem_addr), 32'd32);
        checkOutput("redir_valid", 32'(bus.if_id_valid), 32'd0);
        checkOutput("redir_instr", bus.if_id_instr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        checkOutput("target_instr", bus.if_id_instr, 32'h0064_2820);
        checkOutput("target_pc4", 32'(bus.if_id_pc4), 32'd36);

        // Redirect and stall together with an unaligned target.
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h007);
        checkOutput("align_pc", 32'(bus.imem_addr), 32'd4);
        checkOutput("align_valid", 32'(bus.if_id_valid), 32'd0);
        checkOutput("align_count", 32'(bus.fetch_count), 32'd6);

        // Wrap from the top word of memory.
        applyStimulus(1'b1, 1'b0, 1'b1, 10'd1020);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        checkOutput("wrap_instr", bus.if_id_instr, 32'hDEAD_0FFC);
        checkOutput("wrap_pc4", 32'(bus.if_id_pc4), 32'd0);
        checkOutput("wrap_pc", 32'(bus.imem_addr), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        checkOutput("wrap_next", bus.if_id_instr, 32'h2021_0001);

        // Reset during a stall, then during a redirect.
        applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0);
        checkOutput("rst_stall_count", 32'(bus.fetch_count), 32'd0);
        checkOutput("rst_stall_pc", 32'(bus.imem_addr), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd200);
        checkOutput("rst_redir_pc", 32'(bus.imem_addr), 32'd0);

        // Random mix of stalls, redirects and occasional resets.
        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 9) == 0, 10'($urandom_range(0, 1023)));
        end

        // Saturate the fetch counter.
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0);
        for (int n = 0; n < 65540; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
        end
        checkOutput("count_saturated", 32'(bus.fetch_count), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
